// File: rtl/status_value_queue.sv
// Registered status-value queue with the head fixed at entry 0: push at the tail,
// retire up to MAX_PULL entries from the head, in-place updates that follow the shift.
module status_value_queue #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int MAX_PULL = 2,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int PC_W    = $clog2(MAX_PULL + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       value_i,
    output logic                   push_rdy_o,
    input  logic                   pull_i,
    input  logic [PC_W-1:0]        pull_cnt_i,
    input  logic                   upd_en_i,
    input  logic [IDX_W-1:0]       upd_idx_i,
    input  logic [WIDTH-1:0]       upd_val_i,
    output logic [DEPTH*WIDTH-1:0] vector_o,
    output logic [DEPTH-1:0]       valid_o,
    output logic [CNT_W-1:0]       count_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   push_drop_o,
    output logic                   pull_err_o
);

    logic [WIDTH-1:0] entries_q [DEPTH];
    logic [WIDTH-1:0] entries_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic             empty_q;
    logic             full_q;
    logic             drop_q;
    logic             err_q;

    logic [CNT_W-1:0] pull_req;
    logic [CNT_W-1:0] pull_eff;
    logic [CNT_W-1:0] remain;
    logic             push_ok;
    logic             upd_hit;
    logic [IDX_W-1:0] upd_slot;
    logic [IDX_W-1:0] push_slot;
    logic             drop_d;
    logic             err_d;

    // Effective pull is clamped to the live count so the shift can never wrap.
    always_comb begin
        pull_req   = CNT_W'(pull_cnt_i);
        pull_eff   = '0;
        if (pull_i) begin
            pull_eff = (pull_req < count_q) ? pull_req : count_q;
        end
        remain     = count_q - pull_eff;
        push_rdy_o = remain < CNT_W'(DEPTH);
        push_ok    = push_i & push_rdy_o & ~flush_i;
        drop_d     = push_i & ~push_rdy_o & ~flush_i;
        err_d      = pull_i & ~flush_i & (pull_req > count_q);
        upd_hit    = upd_en_i & (CNT_W'(upd_idx_i) < count_q) & (CNT_W'(upd_idx_i) >= pull_eff);
        upd_slot   = upd_idx_i - pull_eff[IDX_W-1:0];
        push_slot  = remain[IDX_W-1:0];
        count_d    = push_ok ? remain + CNT_W'(1) : remain;
    end

    // Shift survivors toward the head, then layer the update and the push on top.
    // The update slot is always below the push slot, so the two never collide.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            entries_d[j] = '0;
            if (CNT_W'(j) < remain) begin
                entries_d[j] = entries_q[IDX_W'(j) + pull_eff[IDX_W-1:0]];
            end
        end
        if (upd_hit) begin
            entries_d[upd_slot] = upd_val_i;
        end
        if (push_ok) begin
            entries_d[push_slot] = value_i;
        end
    end

    always_comb begin
        valid_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = CNT_W'(i) < count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
            valid_q <= valid_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        vector_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vector_o[i*WIDTH +: WIDTH] = entries_q[i];
        end
    end

    assign valid_o     = valid_q;
    assign count_o     = count_q;
    assign empty_o     = empty_q;
    assign full_o      = full_q;
    assign push_drop_o = drop_q;
    assign pull_err_o  = err_q;

endmodule

// File: tb/tb_status_value_queue.sv
// Directed self-checking bench for status_value_queue (WIDTH=4, DEPTH=8, MAX_PULL=2);
// expected vectors are hand-packed with entry 0 in the lowest nibble.
module tb_status_value_queue;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        flush_i;
    logic        push_i;
    logic [3:0]  value_i;
    logic        push_rdy_o;
    logic        pull_i;
    logic [1:0]  pull_cnt_i;
    logic        upd_en_i;
    logic [2:0]  upd_idx_i;
    logic [3:0]  upd_val_i;
    logic [31:0] vector_o;
    logic [7:0]  valid_o;
    logic [3:0]  count_o;
    logic        empty_o;
    logic        full_o;
    logic        push_drop_o;
    logic        pull_err_o;

    int checks = 0;
    int errors = 0;

    status_value_queue #(.WIDTH(4), .DEPTH(8), .MAX_PULL(2)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .flush_i    (flush_i),
        .push_i     (push_i),
        .value_i    (value_i),
        .push_rdy_o (push_rdy_o),
        .pull_i     (pull_i),
        .pull_cnt_i (pull_cnt_i),
        .upd_en_i   (upd_en_i),
        .upd_idx_i  (upd_idx_i),
        .upd_val_i  (upd_val_i),
        .vector_o   (vector_o),
        .valid_o    (valid_o),
        .count_o    (count_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .push_drop_o(push_drop_o),
        .pull_err_o (pull_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic applyStimulus(input logic rst_n, input logic flush, input logic push,
                                 input logic [3:0] value, input logic pull, input logic [1:0] pcnt,
                                 input logic upd, input logic [2:0] idx, input logic [3:0] uval);
        rst_n_i    = rst_n;
        flush_i    = flush;
        push_i     = push;
        value_i    = value;
        pull_i     = pull;
        pull_cnt_i = pcnt;
        upd_en_i   = upd;
        upd_idx_i  = idx;
        upd_val_i  = uval;
    endtask

    // Advance one edge and sample 1 ns later, away from the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 4'h0);
    endtask

    task automatic pushValue(input logic [3:0] v);
        applyStimulus(1'b1, 1'b0, 1'b1, v, 1'b0, 2'd0, 1'b0, 3'd0, 4'h0);
        tick();
    endtask

    task automatic doFlush();
        applyStimulus(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 3'd0, 4'h0);
        tick();
        idle();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        idle();
        rst_n_i = 1'b0;
        tick();
        tick();
        checkOutput("rst_vector", vector_o, 32'h0);
        checkOutput("rst_valid", 32'(valid_o), 32'h0);
        checkOutput("rst_count", 32'(count_o), 32'd0);
        checkOutput("rst_empty", 32'(empty_o), 32'd1);
        checkOutput("rst_full", 32'(full_o), 32'd0);
        checkOutput("rst_drop", 32'(push_drop_o), 32'd0);
        checkOutput("rst_err", 32'(pull_err_o), 32'd0);
        idle();

        pushValue(4'h1);
        pushValue(4'h2);
        pushValue(4'h3);
        idle();
        checkOutput("p3_count", 32'(count_o), 32'd3);
        checkOutput("p3_valid", 32'(valid_o), 32'h07);
        checkOutput("p3_vector", vector_o, 32'h0000_0321);
        checkOutput("p3_empty", 32'(empty_o), 32'd0);

        for (int v = 4; v <= 8; v++) pushValue(4'(v));
        idle();
        checkOutput("fill_count", 32'(count_o), 32'd8);
        checkOutput("fill_full", 32'(full_o), 32'd1);
        checkOutput("fill_vector", vector_o, 32'h8765_4321);

        applyStimulus(1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 2'd0, 1'b0, 3'd0, 4'h0);
        #1;
        checkOutput("full_rdy", 32'(push_rdy_o), 32'd0);
        tick();
        idle();
        checkOutput("drop_pulse", 32'(push_drop_o), 32'd1);
        checkOutput("drop_vector", vector_o, 32'h8765_4321);
        checkOutput("drop_count", 32'(count_o), 32'd8);
        tick();
        checkOutput("drop_clear", 32'(push_drop_o), 32'd0);

        applyStimulus(1'b1, 1'b0, 1'b1, 4'h9, 1'b1, 2'd1, 1'b0, 3'd0, 4'h0);
        #1;
        checkOutput("full_pull_rdy", 32'(push_rdy_o), 32'd1);
        tick();
        idle();
        checkOutput("pp_vector", vector_o, 32'h9876_5432);
        checkOutput("pp_full", 32'(full_o), 32'd1);
        checkOutput("pp_drop", 32'(push_drop_o), 32'd0);

        doFlush();
        pushValue(4'h5);
        pushValue(4'h6);
        pushValue(4'h7);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 2'd2, 1'b0, 3'd0, 4'h0);
        tick();
        idle();
        checkOutput("p2push_vector", vector_o, 32'h0000_00A7);
        checkOutput("p2push_count", 32'(count_o), 32'd2);
        checkOutput("p2push_valid", 32'(valid_o), 32'h03);

        doFlush();
        for (int v = 1; v <= 4; v++) pushValue(4'(v));
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1, 3'd2, 4'hF);
        tick();
        checkOutput("upd_follow_vector", vector_o, 32'h0000_04F2);
        checkOutput("upd_follow_count", 32'(count_o), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1, 3'd0, 4'hE);
        tick();
        idle();
        checkOutput("upd_retired_vector", vector_o, 32'h0000_004F);
        checkOutput("upd_retired_count", 32'(count_o), 32'd2);

        doFlush();
        pushValue(4'h7);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 3'd0, 4'h0);
        tick();
        idle();
        checkOutput("perr_pulse", 32'(pull_err_o), 32'd1);
        checkOutput("perr_count", 32'(count_o), 32'd0);
        checkOutput("perr_empty", 32'(empty_o), 32'd1);
        checkOutput("perr_vector", vector_o, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b1, 3'd5, 4'hC);
        tick();
        idle();
        checkOutput("perr_clear", 32'(pull_err_o), 32'd0);
        checkOutput("upd_empty_vector", vector_o, 32'h0);
        checkOutput("upd_empty_count", 32'(count_o), 32'd0);

        for (int v = 1; v <= 6; v++) pushValue(4'(v));
        checkOutput("six_count", 32'(count_o), 32'd6);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'h9, 1'b1, 2'd2, 1'b1, 3'd1, 4'hB);
        tick();
        idle();
        checkOutput("flush_count", 32'(count_o), 32'd0);
        checkOutput("flush_vector", vector_o, 32'h0);
        checkOutput("flush_valid", 32'(valid_o), 32'h0);
        checkOutput("flush_empty", 32'(empty_o), 32'd1);
        checkOutput("flush_drop", 32'(push_drop_o), 32'd0);
        checkOutput("flush_err", 32'(pull_err_o), 32'd0);

        for (int v = 1; v <= 8; v++) pushValue(4'(v));
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 2'd1, 1'b0, 3'd0, 4'h0);
        tick();
        idle();
        checkOutput("midrst_count", 32'(count_o), 32'd0);
        checkOutput("midrst_vector", vector_o, 32'h0);
        checkOutput("midrst_full", 32'(full_o), 32'd0);
        checkOutput("midrst_empty", 32'(empty_o), 32'd1);
        checkOutput("midrst_drop", 32'(push_drop_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
